sram_ctrl: RTL and testbench
============================

SRAM_CTRL -- requirements
Module: sram_ctrl

Interface
REQ-001 Parameter SETTLE_CYC, default 1, read-settle cycles (1..3) between driving mem_w=0 and sampling mem_q.
REQ-002 Parameter VERIFY, default 1, 1 = every write followed by read-back compare; 0 = no read-back.
REQ-003 One clock; reset is synchronous and active-low.
REQ-004 clk  in  1  sole clock, rising edge.
REQ-005 rst_n  in  1  synchronous active-low reset.
REQ-006 req_valid  in  1  request present.
REQ-007 req_ready  out  1  controller can accept a request.
REQ-008 req_we  in  1  1 = word write, 0 = word read.
REQ-009 req_addr  in  2  word (row) address.
REQ-010 req_data  in  4  write data.
REQ-011 rsp_valid  out  1  response present.
REQ-012 rsp_ready  in  1  response consumer accepts.
REQ-013 rsp_data  out  4  read data or verify read-back.
REQ-014 rsp_err  out  1  verify mismatch.
REQ-015 mem_d  out  4  array data bus.
REQ-016 mem_row  out  2  array row select.
REQ-017 mem_col  out  2  array bit-column select.
REQ-018 mem_w  out  1  array write strobe.
REQ-019 mem_q  in  4  array row read data.

Function
REQ-020 All outputs registered; request transfer on rising edge with req_valid=1 and req_ready=1.
REQ-021 States IDLE, WR, RD, RSP; req_ready=1 only in IDLE.
REQ-022 Acceptance latches addr/data/we; mem_row=addr and mem_d=data held constant until return to IDLE.
REQ-023 Write: IDLE->WR; four WR cycles, mem_w=1, mem_col=0,1,2,3 (one bit-column per cycle); mem_col wraps to 0 on leaving WR.
REQ-024 After WR: VERIFY=1 -> RD; VERIFY=0 -> RSP, rsp_data=latched data, rsp_err=0.
REQ-025 Read request: IDLE->RD directly; no WR cycles.
REQ-026 RD: mem_w=0, mem_col=0, lasts SETTLE_CYC cycles; mem_q sampled on the last RD edge into rsp_data.
REQ-027 Verify: rsp_err=1 iff sampled mem_q != latched data; read requests always rsp_err=0.
REQ-028 Latency from accept edge T (SETTLE_CYC=1): write+verify rsp_valid at T+6; write no-verify at T+5; read at T+2.
REQ-029 RSP: rsp_valid=1, rsp_data/rsp_err stable until rsp_ready=1 edge, then IDLE with req_ready=1 next cycle.
REQ-030 rsp_ready=1 present on entry to RSP: response held exactly one cycle.
REQ-031 req_valid while busy is ignored, never latched; changes to req_* after acceptance have no effect.
REQ-032 mem_w never 1 outside WR; mem_row/mem_d never change while mem_w=1.

Reset
REQ-033 rst_n=0 at any edge, including mid-WR or mid-RSP: next cycle state=IDLE, req_ready=1 after release, rsp_valid=0, rsp_data=0, rsp_err=0, mem_w=0, mem_d=0, mem_row=0, mem_col=0.
REQ-034 A write aborted by reset issues no further mem_w pulses and produces no response.

Structure
REQ-035 Shared header sram_defs.vh holds state encodings, DATA_W=4, ADDR_W=2, COL_N=4.
REQ-036 One sub-module col_cnt: 2-bit column counter with sync clear and enable, terminal-count output.

Verification
REQ-037 Bench models the array behaviourally (bit write on mem_w at mem_row/mem_col, row read on mem_q).
REQ-038 Write addr=2 data=4'hA, VERIFY=1 -> mem_w high 4 cycles, cols 0..3, rsp_valid at T+6, rsp_data=4'hA, rsp_err=0.
REQ-039 Write addr=1 data=4'h5 with model forcing col 2 stuck-at-0 -> rsp_data=4'h1, rsp_err=1.
REQ-040 Read addr=2 after test 1 -> rsp_valid at T+2, rsp_data=4'hA, no mem_w pulse.
REQ-041 rsp_ready held low 5 cycles -> rsp_valid and rsp_data stable; req_valid meanwhile ignored, req_ready=0.
REQ-042 rst_n low during 2nd WR cycle -> mem_w=0 next cycle, no response, req_ready=1 after release, prior row contents intact except bits already written.

Source files
------------

// File: rtl/sram_ctrl_pkg.sv
// Shared types and sizes for the bit-column SRAM controller.
package sram_ctrl_pkg;

  localparam int unsigned DATA_W = 4;
  localparam int unsigned ADDR_W = 2;
  localparam int unsigned COL_N  = 4;
  localparam int unsigned COL_W  = $clog2(COL_N);
  localparam int unsigned SET_W  = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WR   = 2'd1,
    ST_RD   = 2'd2,
    ST_RSP  = 2'd3
  } state_e;

  // Request fields captured at acceptance and held for the whole transaction.
  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } req_t;

endpackage

// File: rtl/sram_ctrl_col_cnt.sv
// Bit-column counter: sync clear, enable, terminal count on the last column.
module sram_ctrl_col_cnt
  import sram_ctrl_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             en,
  output logic [COL_W-1:0] cnt,
  output logic             tc_c
);

  logic [COL_W-1:0] cnt_q;
  logic [COL_W-1:0] cnt_d;

  // Next count: clear wins over enable; increment wraps naturally at COL_N.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = cnt_q + COL_W'(1);
    end
  end

  // Count register with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign tc_c = (cnt_q == COL_W'(COL_N - 1));

endmodule

// File: rtl/sram_ctrl.sv
// Word-level request/response front end for a bit-column-written SRAM array,
// with optional read-back verification of every write.
module sram_ctrl
  import sram_ctrl_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 1,
  parameter bit          VERIFY     = 1'b1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_data,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [DATA_W-1:0] rsp_data,
  output logic              rsp_err,
  output logic [DATA_W-1:0] mem_d,
  output logic [ADDR_W-1:0] mem_row,
  output logic [COL_W-1:0]  mem_col,
  output logic              mem_w,
  input  logic [DATA_W-1:0] mem_q
);

  state_e            state_q,     state_d;
  req_t              req_q,       req_d;
  logic [SET_W-1:0]  settle_q,    settle_d;
  logic              req_ready_q, req_ready_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [DATA_W-1:0] rsp_data_q,  rsp_data_d;
  logic              rsp_err_q,   rsp_err_d;
  logic              mem_w_q,     mem_w_d;

  logic              col_clr;
  logic              col_en;
  logic              col_tc;
  logic [COL_W-1:0]  col_cnt;

  // Column counter steps only while writing; held at zero everywhere else.
  sram_ctrl_col_cnt u_col_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr   (col_clr),
    .en    (col_en),
    .cnt   (col_cnt),
    .tc_c  (col_tc)
  );

  // Next-state and next-output logic; outputs track the next state so they
  // change on the same edge as the state itself.
  always_comb begin
    state_d     = state_q;
    req_d       = req_q;
    settle_d    = settle_q;
    rsp_valid_d = rsp_valid_q;
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    col_clr     = 1'b1;
    col_en      = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (req_valid && req_ready_q) begin
          req_d    = '{we: req_we, addr: req_addr, data: req_data};
          settle_d = '0;
          state_d  = req_we ? ST_WR : ST_RD;
        end
      end

      ST_WR: begin
        col_clr = 1'b0;
        col_en  = 1'b1;
        if (col_tc) begin
          if (VERIFY) begin
            settle_d = '0;
            state_d  = ST_RD;
          end else begin
            rsp_data_d = req_q.data;
            rsp_err_d  = 1'b0;
            state_d    = ST_RSP;
          end
        end
      end

      ST_RD: begin
        // Array output is sampled only on the last settle cycle.
        if (settle_q == SET_W'(SETTLE_CYC - 1)) begin
          rsp_data_d = mem_q;
          rsp_err_d  = req_q.we && (mem_q != req_q.data);
          state_d    = ST_RSP;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end

      ST_RSP: begin
        // Valid rises one cycle after entry and drops on the accepting edge.
        if (rsp_valid_q && rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = ST_IDLE;
        end else begin
          rsp_valid_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase

    req_ready_d = (state_d == ST_IDLE);
    mem_w_d     = (state_d == ST_WR);
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      req_q       <= '0;
      settle_q    <= '0;
      req_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_data_q  <= '0;
      rsp_err_q   <= 1'b0;
      mem_w_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      req_q       <= req_d;
      settle_q    <= settle_d;
      req_ready_q <= req_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_data_q  <= rsp_data_d;
      rsp_err_q   <= rsp_err_d;
      mem_w_q     <= mem_w_d;
    end
  end

  assign req_ready = req_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_data  = rsp_data_q;
  assign rsp_err   = rsp_err_q;
  assign mem_w     = mem_w_q;
  assign mem_row   = req_q.addr;
  assign mem_d     = req_q.data;
  assign mem_col   = col_cnt;

endmodule

// File: tb/tb_sram_ctrl.sv
// Directed bench for sram_ctrl against a behavioural bit-column array model.
module tb_sram_ctrl;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req_valid;
  logic       req_ready;
  logic       req_we;
  logic [1:0] req_addr;
  logic [3:0] req_data;
  logic       rsp_valid;
  logic       rsp_ready;
  logic [3:0] rsp_data;
  logic       rsp_err;
  logic [3:0] mem_d;
  logic [1:0] mem_row;
  logic [1:0] mem_col;
  logic       mem_w;
  logic [3:0] mem_q;

  logic [3:0] arr [4];
  logic       init_arr;
  logic       stuck;
  int         wr_pulses = 0;

  int vectors    = 0;
  int miscompares = 0;

  sram_ctrl #(.SETTLE_CYC(1), .VERIFY(1'b1)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_we    (req_we),
    .req_addr  (req_addr),
    .req_data  (req_data),
    .rsp_valid (rsp_valid),
    .rsp_ready (rsp_ready),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .mem_d     (mem_d),
    .mem_row   (mem_row),
    .mem_col   (mem_col),
    .mem_w     (mem_w),
    .mem_q     (mem_q)
  );

  always #5 clk = ~clk;

  // Array model: one bit written per strobe, whole row read back.
  always @(posedge clk) begin
    if (init_arr) begin
      arr[0] <= 4'h9;
      arr[1] <= 4'hC;
      arr[2] <= 4'h0;
      arr[3] <= 4'h6;
    end else if (mem_w) begin
      arr[mem_row][mem_col] <= mem_d[mem_col];
      wr_pulses <= wr_pulses + 1;
    end
  end

  // Row read with an optional stuck-at-0 defect on row 1, column 2.
  always_comb begin
    mem_q = arr[mem_row];
    if (stuck && (mem_row == 2'd1)) mem_q[2] = 1'b0;
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic we, input logic [1:0] addr, input logic [3:0] data);
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_data  = data;
  endtask

  initial begin
    int base;
    logic saw_w;
    logic saw_rsp;

    rst_n     = 1'b0;
    init_arr  = 1'b1;
    stuck     = 1'b0;
    req_valid = 1'b0;
    req_we    = 1'b0;
    req_addr  = '0;
    req_data  = '0;
    rsp_ready = 1'b1;

    // Reset
    repeat (3) tick();
    init_arr = 1'b0;
    chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
    chk("rst_rsp_data",  32'(rsp_data),  32'h0);
    chk("rst_rsp_err",   32'(rsp_err),   32'h0);
    chk("rst_mem_w",     32'(mem_w),     32'h0);
    chk("rst_mem_d",     32'(mem_d),     32'h0);
    chk("rst_mem_row",   32'(mem_row),   32'h0);
    chk("rst_mem_col",   32'(mem_col),   32'h0);
    rst_n = 1'b1;
    tick();
    chk("rst_req_ready", 32'(req_ready), 32'h1);

    // Write addr 2 data A with verify
    base = wr_pulses;
    send(1'b1, 2'd2, 4'hA);
    tick();                                    // T
    req_valid = 1'b0;
    chk("w1_mem_w0",   32'(mem_w),     32'h1);
    chk("w1_col0",     32'(mem_col),   32'h0);
    chk("w1_row",      32'(mem_row),   32'h2);
    chk("w1_mem_d",    32'(mem_d),     32'hA);
    chk("w1_busy",     32'(req_ready), 32'h0);
    for (int k = 1; k < 4; k++) begin
      tick();                                  // T+k
      chk("w1_mem_w", 32'(mem_w),   32'h1);
      chk("w1_col",   32'(mem_col), 32'(k));
    end
    tick();                                    // T+4
    chk("w1_w_drop",   32'(mem_w),     32'h0);
    chk("w1_col_wrap", 32'(mem_col),   32'h0);
    tick();                                    // T+5
    chk("w1_no_rsp5",  32'(rsp_valid), 32'h0);
    tick();                                    // T+6
    chk("w1_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("w1_rsp_data",  32'(rsp_data),  32'hA);
    chk("w1_rsp_err",   32'(rsp_err),   32'h0);
    chk("w1_pulses",    32'(wr_pulses - base), 32'h4);
    chk("w1_arr2",      32'(arr[2]),    32'hA);
    tick();                                    // T+7
    chk("w1_rsp_once",  32'(rsp_valid), 32'h0);
    chk("w1_ready",     32'(req_ready), 32'h1);

    // Write addr 1 data 5 with column 2 stuck at 0
    stuck = 1'b1;
    send(1'b1, 2'd1, 4'h5);
    tick();
    req_valid = 1'b0;
    repeat (5) tick();
    chk("w2_no_rsp5",   32'(rsp_valid), 32'h0);
    tick();
    chk("w2_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("w2_rsp_data",  32'(rsp_data),  32'h1);
    chk("w2_rsp_err",   32'(rsp_err),   32'h1);
    tick();
    chk("w2_rsp_once",  32'(rsp_valid), 32'h0);
    stuck = 1'b0;

    // Read addr 2, then hold the response under backpressure
    base = wr_pulses;
    rsp_ready = 1'b0;
    send(1'b0, 2'd2, 4'h0);
    tick();                                    // T
    req_valid = 1'b0;
    chk("r_mem_w",     32'(mem_w),     32'h0);
    chk("r_row",       32'(mem_row),   32'h2);
    chk("r_col",       32'(mem_col),   32'h0);
    tick();                                    // T+1
    chk("r_no_rsp1",   32'(rsp_valid), 32'h0);
    tick();                                    // T+2
    chk("r_rsp_valid", 32'(rsp_valid), 32'h1);
    chk("r_rsp_data",  32'(rsp_data),  32'hA);
    chk("r_rsp_err",   32'(rsp_err),   32'h0);
    send(1'b1, 2'd3, 4'hF);
    for (int k = 0; k < 5; k++) begin
      tick();
      chk("bp_valid", 32'(rsp_valid), 32'h1);
      chk("bp_data",  32'(rsp_data),  32'hA);
      chk("bp_busy",  32'(req_ready), 32'h0);
      chk("bp_row",   32'(mem_row),   32'h2);
    end
    req_valid = 1'b0;
    rsp_ready = 1'b1;
    tick();
    chk("bp_release", 32'(rsp_valid), 32'h0);
    chk("bp_ready",   32'(req_ready), 32'h1);
    chk("r_pulses",   32'(wr_pulses - base), 32'h0);
    chk("bp_arr3",    32'(arr[3]),    32'h6);

    // Reset during the second WR cycle of a write to row 0
    base = wr_pulses;
    send(1'b1, 2'd0, 4'h6);
    tick();                                    // T: first WR cycle
    req_valid = 1'b0;
    tick();                                    // T+1: second WR cycle
    chk("ab_in_wr", 32'(mem_w), 32'h1);
    rst_n = 1'b0;
    tick();                                    // T+2: reset sampled
    chk("ab_mem_w",   32'(mem_w),     32'h0);
    chk("ab_rsp",     32'(rsp_valid), 32'h0);
    chk("ab_col",     32'(mem_col),   32'h0);
    chk("ab_mem_d",   32'(mem_d),     32'h0);
    chk("ab_row",     32'(mem_row),   32'h0);
    rst_n = 1'b1;
    saw_w   = 1'b0;
    saw_rsp = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      if (mem_w)     saw_w   = 1'b1;
      if (rsp_valid) saw_rsp = 1'b1;
    end
    chk("ab_no_w",    32'(saw_w),     32'h0);
    chk("ab_no_rsp",  32'(saw_rsp),   32'h0);
    chk("ab_ready",   32'(req_ready), 32'h1);
    chk("ab_pulses",  32'(wr_pulses - base), 32'h2);
    chk("ab_arr0",    32'(arr[0]),    32'hA);
    chk("ab_arr2",    32'(arr[2]),    32'hA);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
